// File: rtl/schmitt_pkg.sv
// Shared definitions for the Schmitt trigger block.
//   state_t        : comparator FSM states; the output square wave is high
//                    in HIGH and FALL_PEND.
//   deb_cnt_width  : bits needed to hold a debounce count of 0..deb_cycles.
package schmitt_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } state_t;

    function automatic int deb_cnt_width(input int deb_cycles);
        return $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as the rise-to-rise period counter.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, count -> 0
//   clr    : synchronous clear, takes priority over en
//   en     : count up by one, sticking at all-ones
//   count  : current count
//   at_max : count is all-ones (saturated)
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != MAX_COUNT)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == MAX_COUNT);

endmodule

// File: rtl/schmitt_trigger.sv
// Clocked comparator with hysteresis and debounce. A sample stream is turned
// into a clean square wave with rise/fall strobes and a rise-to-rise period.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   sample_valid  : wave carries a new sample this cycle
//   wave          : unsigned sample
//   thr_hi/thr_lo : rising / falling thresholds (strict comparisons)
//   square_wave   : debounced comparator state
//   rise_pulse    : one-cycle strobe on a 0->1 transition of square_wave
//   fall_pulse    : one-cycle strobe on a 1->0 transition of square_wave
//   period        : valid samples between the last two accepted rises
//   period_valid  : one-cycle strobe when period updates
//   thr_err       : high while the last valid sample saw thr_lo > thr_hi
module schmitt_trigger
    import schmitt_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] wave,
    input  logic [WIDTH-1:0] thr_hi,
    input  logic [WIDTH-1:0] thr_lo,
    output logic             square_wave,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             thr_err
);

    localparam int               DEB_W      = deb_cnt_width(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEB_CYCLES);

    state_t           state_reg, state_next;
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic [DEB_W-1:0] deb_inc;

    logic             square_wave_reg;
    logic             rise_pulse_reg;
    logic             fall_pulse_reg;
    logic [CNT_W-1:0] period_reg;
    logic             period_valid_reg;
    logic             thr_err_reg;
    logic             first_rise_reg;

    logic             thr_bad;
    logic             above_hi;
    logic             below_lo;
    logic             step;
    logic             rise_accept;
    logic             fall_accept;

    logic [CNT_W-1:0] cnt_value;
    logic [CNT_W-1:0] cnt_plus;
    logic             cnt_at_max;

    assign thr_bad  = (thr_lo > thr_hi);
    assign above_hi = (wave > thr_hi);
    assign below_lo = (wave < thr_lo);
    // Illegal thresholds freeze the FSM, debounce and period counter.
    assign step     = sample_valid & ~thr_bad;
    assign deb_inc  = deb_cnt_reg + DEB_W'(1);

    // Next-state logic. The debounce count restarts whenever a sample fails
    // to qualify, so qualifying samples must be consecutive valid samples.
    always_comb begin
        state_next   = state_reg;
        deb_cnt_next = deb_cnt_reg;
        rise_accept  = 1'b0;
        fall_accept  = 1'b0;
        if (step) begin
            case (state_reg)
                LOW: begin
                    if (above_hi) begin
                        if (DEB_CYCLES == 1) begin
                            state_next  = HIGH;
                            rise_accept = 1'b1;
                        end else begin
                            state_next   = RISE_PEND;
                            deb_cnt_next = DEB_W'(1);
                        end
                    end
                end
                RISE_PEND: begin
                    if (above_hi) begin
                        if (deb_inc == DEB_TARGET) begin
                            state_next   = HIGH;
                            deb_cnt_next = '0;
                            rise_accept  = 1'b1;
                        end else begin
                            deb_cnt_next = deb_inc;
                        end
                    end else begin
                        state_next   = LOW;
                        deb_cnt_next = '0;
                    end
                end
                HIGH: begin
                    if (below_lo) begin
                        if (DEB_CYCLES == 1) begin
                            state_next  = LOW;
                            fall_accept = 1'b1;
                        end else begin
                            state_next   = FALL_PEND;
                            deb_cnt_next = DEB_W'(1);
                        end
                    end
                end
                FALL_PEND: begin
                    if (below_lo) begin
                        if (deb_inc == DEB_TARGET) begin
                            state_next   = LOW;
                            deb_cnt_next = '0;
                            fall_accept  = 1'b1;
                        end else begin
                            deb_cnt_next = deb_inc;
                        end
                    end else begin
                        state_next   = HIGH;
                        deb_cnt_next = '0;
                    end
                end
                default: begin
                    state_next   = LOW;
                    deb_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= LOW;
            deb_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            deb_cnt_reg <= deb_cnt_next;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_period_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (rise_accept),
        .en     (step),
        .count  (cnt_value),
        .at_max (cnt_at_max)
    );

    // Period reported on a rise includes the rising sample itself.
    assign cnt_plus = cnt_at_max ? cnt_value : (cnt_value + CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            square_wave_reg  <= 1'b0;
            rise_pulse_reg   <= 1'b0;
            fall_pulse_reg   <= 1'b0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            thr_err_reg      <= 1'b0;
            first_rise_reg   <= 1'b1;
        end else begin
            square_wave_reg  <= (state_next == HIGH) || (state_next == FALL_PEND);
            rise_pulse_reg   <= rise_accept;
            fall_pulse_reg   <= fall_accept;
            period_valid_reg <= 1'b0;
            if (sample_valid) begin
                thr_err_reg <= thr_bad;
            end
            // The first rise after reset has no previous rise to measure from.
            if (rise_accept) begin
                first_rise_reg <= 1'b0;
                if (!first_rise_reg) begin
                    period_reg       <= cnt_plus;
                    period_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign square_wave  = square_wave_reg;
    assign rise_pulse   = rise_pulse_reg;
    assign fall_pulse   = fall_pulse_reg;
    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign thr_err      = thr_err_reg;

endmodule

// File: tb/tb_schmitt_trigger.sv
// Scoreboard bench for schmitt_trigger. Two instances share the stimulus:
// dut uses a 16-bit period counter, dut_s a 4-bit one that saturates at 15.
module tb_schmitt_trigger;

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        bit pv;
        int period;
        bit sq;
        bit err;
    } evt_t;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [7:0]  wave;
    logic [7:0]  thr_hi;
    logic [7:0]  thr_lo;

    logic        d_sq, d_rise, d_fall, d_pv, d_err;
    logic [15:0] d_period;
    logic        s_sq, s_rise, s_fall, s_pv, s_err;
    logic [3:0]  s_period;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 0;
    evt_t q[$];
    evt_t qs[$];

    // bench-side expectation state
    int   m_cnt;
    bit   m_first;
    bit   m_sq;
    bit   m_err;

    schmitt_trigger #(.WIDTH(8), .DEB_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .wave(wave),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .square_wave(d_sq),
        .rise_pulse(d_rise), .fall_pulse(d_fall), .period(d_period),
        .period_valid(d_pv), .thr_err(d_err)
    );

    schmitt_trigger #(.WIDTH(8), .DEB_CYCLES(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .wave(wave),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .square_wave(s_sq),
        .rise_pulse(s_rise), .fall_pulse(s_fall), .period(s_period),
        .period_valid(s_pv), .thr_err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic judge(input string nm, input evt_t e, input int c, input bit r,
                         input bit f, input bit pv, input int per, input bit sq, input bit er);
        checks++;
        if (e.cyc != c || r != e.rise || f != e.fall || pv != e.pv || sq != e.sq ||
            er != e.err || (e.pv && per != e.period)) begin
            errors++;
            $display("FAIL %s event: got cyc=%0d rise=%0b fall=%0b pv=%0b period=%0d sq=%0b err=%0b, want cyc=%0d rise=%0b fall=%0b pv=%0b period=%0d sq=%0b err=%0b",
                     nm, c, r, f, pv, per, sq, er, e.cyc, e.rise, e.fall, e.pv, e.period, e.sq, e.err);
        end else begin
            $display("ok %s event cyc=%0d rise=%0b fall=%0b pv=%0b period=%0d sq=%0b err=%0b",
                     nm, c, r, f, pv, per, sq, er);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
        end else begin
            $display("ok %s = %0d", nm, act);
        end
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin : mon_main
        evt_t e;
        bit   ev;
        bit   err_prev;
        ev = d_rise | d_fall | d_pv | (d_err != err_prev);
        if (armed) begin
            if (ev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL main unexpected event at cyc=%0d rise=%0b fall=%0b pv=%0b err=%0b",
                             cyc, d_rise, d_fall, d_pv, d_err);
                end else begin
                    e = q.pop_front();
                    judge("main", e, cyc, d_rise, d_fall, d_pv, int'(d_period), d_sq, d_err);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL main missing event: got none at cyc=%0d, want cyc=%0d rise=%0b fall=%0b err=%0b",
                         cyc, e.cyc, e.rise, e.fall, e.err);
            end
        end
        err_prev = d_err;
    end

    // Monitor for the 4-bit (saturating) instance.
    always @(negedge clk) begin : mon_sat
        evt_t e;
        bit   ev;
        bit   err_prev;
        ev = s_rise | s_fall | s_pv | (s_err != err_prev);
        if (armed) begin
            if (ev) begin
                if (qs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sat unexpected event at cyc=%0d rise=%0b fall=%0b pv=%0b err=%0b",
                             cyc, s_rise, s_fall, s_pv, s_err);
                end else begin
                    e = qs.pop_front();
                    judge("sat", e, cyc, s_rise, s_fall, s_pv, int'(s_period), s_sq, s_err);
                end
            end else if (qs.size() > 0 && qs[0].cyc <= cyc) begin
                e = qs.pop_front();
                checks++;
                errors++;
                $display("FAIL sat missing event: got none at cyc=%0d, want cyc=%0d rise=%0b fall=%0b err=%0b",
                         cyc, e.cyc, e.rise, e.fall, e.err);
            end
        end
        err_prev = s_err;
    end

    // One sample, driven just after a falling edge. er/ef mark the sample on
    // which a rise/fall is expected to be accepted.
    task automatic smp(input int w, input bit v, input bit er, input bit ef);
        evt_t e;
        bit   push;
        bit   bad;
        wave         = 8'(w);
        sample_valid = v;
        push = 0;
        e.rise = 0; e.fall = 0; e.pv = 0; e.period = 0;
        if (v) begin
            bad = (thr_lo > thr_hi);
            if (bad != m_err) begin
                m_err = bad;
                push  = 1;
            end
            if (!bad) m_cnt++;
        end
        if (er) begin
            m_sq = 1; push = 1; e.rise = 1;
            if (!m_first) begin
                e.pv = 1;
                e.period = m_cnt;
            end
            m_first = 0;
            m_cnt = 0;
        end
        if (ef) begin
            m_sq = 0; push = 1; e.fall = 1;
        end
        e.sq  = m_sq;
        e.err = m_err;
        e.cyc = cyc + 1;
        if (push) begin
            q.push_back(e);
            if (e.period > 15) e.period = 15;
            qs.push_back(e);
        end
        @(negedge clk);
    endtask

    // n valid samples of value w; the last one may carry an expected edge
    task automatic rep(input int w, input int n, input bit r, input bit f);
        for (int i = 0; i < n; i++) smp(w, 1'b1, r && (i == n - 1), f && (i == n - 1));
    endtask

    // same, with an ignored garbage sample after each valid one
    task automatic rep_t(input int w, input int n, input bit r, input bit f, input int gw);
        for (int i = 0; i < n; i++) begin
            smp(w, 1'b1, r && (i == n - 1), f && (i == n - 1));
            smp(gw, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " square_wave"},  int'(d_sq), 0);
        chk({tag, " rise_pulse"},   int'(d_rise), 0);
        chk({tag, " fall_pulse"},   int'(d_fall), 0);
        chk({tag, " period"},       int'(d_period), 0);
        chk({tag, " period_valid"}, int'(d_pv), 0);
        chk({tag, " thr_err"},      int'(d_err), 0);
        chk({tag, " sat period"},   int'(s_period), 0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b1;
        wave         = 8'd90;
        @(negedge clk);
        rst          = 1'b0;
        sample_valid = 1'b0;
        m_cnt = 0; m_first = 1; m_sq = 0; m_err = 0;
        chk_reset("mid reset");
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; wave = 8'd0;
        thr_hi = 8'd150; thr_lo = 8'd100;
        m_cnt = 0; m_first = 1; m_sq = 0; m_err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("reset");
        armed = 1;

        // first rise: no period_valid
        rep(90, 3, 0, 0);
        rep(160, 4, 1, 0);
        // hysteresis band, wave == thr_lo never falls, then a real fall
        rep(120, 10, 0, 0);
        rep(100, 6, 0, 0);
        rep(99, 4, 0, 1);
        // glitch restarts the debounce count
        rep(160, 3, 0, 0);
        rep(120, 1, 0, 0);
        rep(160, 4, 1, 0);
        // wave == thr_hi never rises
        rep(90, 4, 0, 1);
        rep(150, 8, 0, 0);
        // zero hysteresis
        thr_lo = 8'd150;
        rep(151, 4, 1, 0);
        rep(149, 4, 0, 1);
        thr_lo = 8'd100;
        // 20 valid samples per period with sample_valid toggling
        rep(160, 4, 1, 0);
        for (int k = 0; k < 2; k++) begin
            rep_t(160, 6, 0, 0, 90);
            rep_t(90, 4, 0, 1, 160);
            rep_t(90, 6, 0, 0, 160);
            rep_t(160, 4, 1, 0, 90);
        end
        // 30-sample period: saturates in the 4-bit instance
        rep(160, 10, 0, 0);
        rep(90, 4, 0, 1);
        rep(90, 12, 0, 0);
        rep(160, 4, 1, 0);
        // threshold error mid RISE_PEND freezes, then debounce resumes
        rep(90, 4, 0, 1);
        rep(160, 2, 0, 0);
        thr_lo = 8'd200; thr_hi = 8'd100;
        rep(160, 10, 0, 0);
        thr_lo = 8'd100; thr_hi = 8'd150;
        rep(160, 2, 1, 0);
        // reset during FALL_PEND; next rise is treated as the first
        rep(90, 2, 0, 0);
        do_reset();
        rep(160, 4, 1, 0);
        rep(90, 4, 0, 1);
        repeat (4) smp(0, 1'b0, 1'b0, 1'b0);

        chk("main queue drained", q.size(), 0);
        chk("sat queue drained", qs.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/schmitt_trigger.md
# schmitt_trigger

Parametrised, clocked successor to the combinational 128-level square-wave comparator, with real hysteresis. Programmable high and low thresholds, a consecutive-sample debounce filter, rise/fall edge strobes and a rising-edge-to-rising-edge period counter. Sits between the digital waveform source (DDS/ADC sample stream) and the display/measurement logic. Converts a sampled analog-like wave into a clean square wave plus frequency information.

## Interface
- `WIDTH`, 8: sample and threshold width in bits.
- `DEB_CYCLES`, 4: number of consecutive qualifying valid samples needed to switch state; legal range 1..255.
- `CNT_W`, 16: period counter width in bits.

- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `sample_valid` input 1: the `wave` input holds a new sample this cycle.
- `wave` input WIDTH: unsigned sample.
- `thr_hi` input WIDTH: unsigned rising threshold.
- `thr_lo` input WIDTH: unsigned falling threshold.
- `square_wave` output 1: debounced comparator state.
- `rise_pulse` output 1: one-cycle strobe on a 0→1 transition of `square_wave`.
- `fall_pulse` output 1: one-cycle strobe on a 1→0 transition of `square_wave`.
- `period` output CNT_W: valid samples between the last two accepted rises; holds its value between updates.
- `period_valid` output 1: one-cycle strobe when `period` updates.
- `thr_err` output 1: registered flag, high while `thr_lo > thr_hi`.

## Operation
- The FSM has four states: LOW, RISE_PEND, HIGH, FALL_PEND. `square_wave` is 1 only in HIGH and FALL_PEND.
- The FSM advances only on cycles with `sample_valid=1`. Other cycles hold all state; counters do not advance.
- LOW:
  - `wave > thr_hi` → RISE_PEND, with deb_cnt=1.
  - If DEB_CYCLES=1, go directly to HIGH instead.
- RISE_PEND:
  - `wave > thr_hi` → deb_cnt+1. When the count reaches DEB_CYCLES → HIGH, deb_cnt=0.
  - Any sample `<= thr_hi` → LOW, deb_cnt=0. The count restarts; it does not accumulate across gaps.
- HIGH and FALL_PEND mirror LOW and RISE_PEND, using `wave < thr_lo`.
- Comparisons are strict:
  - `wave == thr_hi` never qualifies a rise.
  - `wave == thr_lo` never qualifies a fall.
  - `thr_hi == thr_lo` is legal and gives zero hysteresis.
- Threshold error:
  - If `thr_lo > thr_hi` on a valid sample: `thr_err=1`, and state, deb_cnt and the period counter freeze.
  - Normal operation resumes on the first valid sample with legal thresholds.
- Thresholds are read on each valid sample. A change to a threshold mid-debounce applies to the remaining samples.
- Period counter:
  - Increments on each valid sample.
  - Saturates at 2^CNT_W−1.
  - On an accepted rise: `period` ← count including the current sample, `period_valid=1`, count ← 0.
  - The first rise after reset only clears the count. `period_valid` stays 0 for that rise.
- Reset (`rst=1` at a clock edge):
  - State LOW, deb_cnt 0, period counter 0, first-rise flag set.
  - `square_wave=0`, `rise_pulse=0`, `fall_pulse=0`, `period=0`, `period_valid=0`, `thr_err=0`.
  - Reset overrides `sample_valid` in the same cycle.
  - Reset mid-debounce discards the pending count.

## Timing
- All outputs are registered.
- `square_wave`, `rise_pulse`/`fall_pulse`, `period` and `period_valid` update on the clock edge that samples the DEB_CYCLES-th qualifying sample. They are visible the next cycle (latency 1 cycle from that sample).
- Strobes are high for exactly one cycle, even if the next cycle has `sample_valid=0`.
- `rise_pulse` and `period_valid` assert in the same cycle.
- `rise_pulse` and `fall_pulse` are never high together.
- Minimum spacing between edges is DEB_CYCLES valid samples.

## Structure
- Shared package `schmitt_pkg`:
  - state enum type: LOW, RISE_PEND, HIGH, FALL_PEND.
  - function computing the deb_cnt width, $clog2(DEB_CYCLES+1).
- Sub-module `sat_counter`: parametrised width, with `clr`, `en` and saturate-at-max. It implements the period counter.
- The debounce counter stays inline.

## Test plan
- Rise with defaults: `thr_hi=150`, `thr_lo=100`. Wave 90 ×3, then 160 ×4 (valid every cycle) → `square_wave` rises 1 cycle after the 4th 160, with `rise_pulse`=1 for one cycle; `period_valid` stays 0 (first rise).
- Glitch rejection: from LOW, wave 160,160,160,120,160 → `square_wave` stays 0 and the debounce count restarts. Three more 160s then produce the rise.
- Hysteresis band: from HIGH, wave 120 ×10 → `square_wave` stays 1. Then 99 ×4 → `fall_pulse` for one cycle and `square_wave=0`. Boundary case: wave=150 repeated from LOW never rises.
- Period: square-ish wave with 20 valid samples between accepted rises, with `sample_valid` toggling 50% → `period=20` and `period_valid` on the 2nd and later rises. With CNT_W=4 and a 30-sample gap → `period=15` (saturated).
- Threshold error: `thr_lo=200`, `thr_hi=100` mid-RISE_PEND → `thr_err=1`, and no state or period change over 10 samples. Restoring legal thresholds → `thr_err=0` and the debounce resumes from its frozen count.
- Reset mid-operation: assert `rst` for 1 cycle during FALL_PEND with `sample_valid=1` → next cycle all outputs are 0 and the state is LOW. The next rise gives no `period_valid`.
